// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam int ADDR_W_DEF     = 64;
    localparam int INSN_BYTES_DEF = 4;
    // FLUSH_CYCLES is limited to 1..7, so three bits cover the countdown
    localparam int CNT_W          = 3;

    // ceil(log2(v)); used to derive the instruction alignment mask and offset shift
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_seq_reg.sv
// Program counter register with load enable and async active-low reset.
module pc_reg
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    // PC holds unless load is asserted
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)  q <= RESET_PC;
        else if (load) q <= d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Front-of-fetch PC sequencer: increment, branch, jump, stall, halt, and a
// fetch-flush window after every redirect.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                INSN_BYTES   = INSN_BYTES_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] BranchOffset,
    input  logic [ADDR_W-1:0] BranchPC,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Halt,
    input  logic              Resume,
    output logic [ADDR_W-1:0] PCout,
    output logic [ADDR_W-1:0] PCplus,
    output logic              FetchValid,
    output logic              Flush,
    output logic [1:0]        State
);

    localparam int                SHIFT      = log2(INSN_BYTES);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSN_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));
    // Counter holds the number of flush cycles remaining after the current one
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(FLUSH_CYCLES - 1);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              taken, pc_load;
    logic [ADDR_W-1:0] target, pc_nxt;

    assign PCplus = PCout + STEP;
    assign State  = state;

    // Redirect decode: jump overrides branch, jump target is forced aligned
    always_comb begin
        taken  = (Branch & Zero) | Jump;
        target = Jump ? (JumpTarget & ALIGN_MASK)
                      : (BranchPC + (BranchOffset << SHIFT));
    end

    // Next-state / next-PC selection, priority Halt > Taken > Stall > increment
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_load   = 1'b0;
        pc_nxt    = PCplus;
        unique case (state)
            HALT: begin
                if (!Halt && Resume) state_nxt = RUN;
            end
            RUN, FLUSH: begin
                if (Halt) begin
                    state_nxt = HALT;
                end else if (taken) begin
                    pc_load   = 1'b1;
                    pc_nxt    = target;
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    pc_load = !Stall;
                    // flush window keeps counting down through stalls
                    if (state == FLUSH) begin
                        if (cnt == '0) state_nxt = RUN;
                        else           cnt_nxt   = cnt - CNT_W'(1);
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // FSM state, flush counter and registered status outputs
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= RUN;
            cnt        <= '0;
            Flush      <= 1'b0;
            FetchValid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            Flush      <= (state_nxt == FLUSH);
            FetchValid <= (state_nxt == RUN);
        end
    end

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .load    (pc_load),
        .d       (pc_nxt),
        .q       (PCout)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (FLUSH_CYCLES 1 and 3) share inputs
// and are compared against a cycle-level behavioural model.
module tb_pc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Stall = 1'b0, Branch = 1'b0, Zero = 1'b0, Jump = 1'b0;
    logic        Halt = 1'b0, Resume = 1'b0;
    logic [63:0] BranchOffset = '0, BranchPC = '0, JumpTarget = '0;

    logic [63:0] pc_a, pcp_a, pc_b, pcp_b;
    logic        fv_a, fl_a, fv_b, fl_b;
    logic [1:0]  st_a, st_b;

    always #5 Clock = ~Clock;

    pc_sequencer dut_a (
        .Clock(Clock), .Reset_n(Reset_n), .Stall(Stall), .Branch(Branch), .Zero(Zero),
        .BranchOffset(BranchOffset), .BranchPC(BranchPC), .Jump(Jump), .JumpTarget(JumpTarget),
        .Halt(Halt), .Resume(Resume), .PCout(pc_a), .PCplus(pcp_a), .FetchValid(fv_a),
        .Flush(fl_a), .State(st_a)
    );

    pc_sequencer #(.FLUSH_CYCLES(3)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n), .Stall(Stall), .Branch(Branch), .Zero(Zero),
        .BranchOffset(BranchOffset), .BranchPC(BranchPC), .Jump(Jump), .JumpTarget(JumpTarget),
        .Halt(Halt), .Resume(Resume), .PCout(pc_b), .PCplus(pcp_b), .FetchValid(fv_b),
        .Flush(fl_b), .State(st_b)
    );

    // Model: mode 0=run 1=flush 2=halt, left = flush cycles still to show
    typedef struct {
        logic [63:0] pc;
        int          mode;
        int          left;
        bit          fv;
        bit          fl;
    } mdl_t;

    mdl_t ma, mb;
    int   checks = 0;
    int   errors = 0;

    function automatic mdl_t mreset();
        mdl_t m;
        m.pc = 64'd0; m.mode = 0; m.left = 0; m.fv = 0; m.fl = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int fc);
        logic [63:0] tgt;
        bit          tk;
        tk  = (Branch && Zero) || Jump;
        tgt = Jump ? (JumpTarget - (JumpTarget % 64'd4)) : (BranchPC + BranchOffset * 64'd4);
        if (m.mode == 2) begin
            if (!Halt && Resume) m.mode = 0;
        end else if (Halt) begin
            m.mode = 2;
        end else if (tk) begin
            m.pc = tgt; m.mode = 1; m.left = fc;
        end else begin
            if (!Stall) m.pc = m.pc + 64'd4;
            if (m.mode == 1) begin
                m.left = m.left - 1;
                if (m.left == 0) m.mode = 0;
            end
        end
        m.fv = (m.mode == 0);
        m.fl = (m.mode == 1);
        return m;
    endfunction

    task automatic tick();
        @(posedge Clock);
        ma = mstep(ma, 1);
        mb = mstep(mb, 3);
        #1;
    endtask

    task automatic clear_in();
        Stall = 0; Branch = 0; Zero = 0; Jump = 0; Halt = 0; Resume = 0;
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0;
        #2;
        ma = mreset();
        mb = mreset();
    endtask

    task automatic release_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_in();
        apply_reset();
        checks++; if (pc_a !== 64'd0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_a); end
        checks++; if (fl_a !== 1'b0 || fv_a !== 1'b0) begin errors++; $display("FAIL reset_flags got fl=%b fv=%b want 0 0", fl_a, fv_a); end
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st_a); end
        checks++; if (pcp_a !== 64'd4) begin errors++; $display("FAIL reset_pcplus got %h want 4", pcp_a); end
        release_reset();
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (pc_a !== 64'(4 * i) || pc_a !== ma.pc) begin errors++; $display("FAIL free_run_pc[%0d] got %h want %h", i, pc_a, 64'(4 * i)); end
            checks++; if (fv_a !== 1'b1 || fl_a !== 1'b0) begin errors++; $display("FAIL free_run_flags[%0d] got fv=%b fl=%b want 1 0", i, fv_a, fl_a); end
            checks++; if (pcp_a !== 64'(4 * i + 4)) begin errors++; $display("FAIL free_run_pcplus[%0d] got %h want %h", i, pcp_a, 64'(4 * i + 4)); end
        end
    endtask

    task automatic test_branch();
        BranchPC = 64'd8; BranchOffset = 64'd3; Branch = 1; Zero = 1;
        tick();
        checks++; if (pc_a !== 64'd20) begin errors++; $display("FAIL branch_taken_pc got %h want 14", pc_a); end
        checks++; if (fl_a !== 1'b1 || fv_a !== 1'b0 || st_a !== 2'd1) begin errors++; $display("FAIL branch_flush got fl=%b fv=%b st=%0d want 1 0 1", fl_a, fv_a, st_a); end
        clear_in();
        tick();
        checks++; if (pc_a !== 64'd24 || fl_a !== 1'b0 || fv_a !== 1'b1) begin errors++; $display("FAIL branch_after got pc=%h fl=%b want 18 0", pc_a, fl_a); end
        Branch = 1; Zero = 0;
        tick();
        checks++; if (pc_a !== 64'd28 || fl_a !== 1'b0) begin errors++; $display("FAIL branch_not_taken got pc=%h fl=%b want 1c 0", pc_a, fl_a); end
        checks++; if (pc_b !== mb.pc || fl_b !== mb.fl) begin errors++; $display("FAIL branch_b got pc=%h fl=%b want %h %b", pc_b, fl_b, mb.pc, mb.fl); end
        clear_in();
    endtask

    task automatic test_jump_wins();
        Jump = 1; JumpTarget = 64'h103; Branch = 1; Zero = 1; BranchPC = 64'd8; BranchOffset = 64'd3;
        tick();
        checks++; if (pc_a !== 64'h100) begin errors++; $display("FAIL jump_wins got %h want 100", pc_a); end
        checks++; if (pc_b !== 64'h100 || fl_b !== 1'b1) begin errors++; $display("FAIL jump_wins_b got pc=%h fl=%b want 100 1", pc_b, fl_b); end
        clear_in();
        tick();
        checks++; if (pc_a !== 64'h104 || fv_a !== 1'b1) begin errors++; $display("FAIL jump_after got pc=%h fv=%b want 104 1", pc_a, fv_a); end
    endtask

    task automatic test_stall();
        Jump = 1; JumpTarget = 64'h40;
        tick();
        clear_in();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_a !== 64'h40 || pc_b !== 64'h40) begin errors++; $display("FAIL stall_hold[%0d] got a=%h b=%h want 40", i, pc_a, pc_b); end
        end
        checks++; if (fl_b !== mb.fl || st_b !== 2'(mb.mode)) begin errors++; $display("FAIL stall_flush_count got fl=%b st=%0d want %b %0d", fl_b, st_b, mb.fl, mb.mode); end
        Jump = 1; JumpTarget = 64'h80;
        tick();
        checks++; if (pc_a !== 64'h80 || fl_a !== 1'b1) begin errors++; $display("FAIL stall_taken got pc=%h fl=%b want 80 1", pc_a, fl_a); end
        clear_in();
        tick();
        checks++; if (pc_a !== 64'h84) begin errors++; $display("FAIL stall_release got %h want 84", pc_a); end
    endtask

    task automatic test_halt();
        Jump = 1; JumpTarget = 64'h20;
        tick();
        clear_in();
        Halt = 1;
        tick();
        checks++; if (pc_a !== 64'h20 || st_a !== 2'd2 || fv_a !== 1'b0 || fl_a !== 1'b0) begin errors++; $display("FAIL halt_enter got pc=%h st=%0d fv=%b fl=%b want 20 2 0 0", pc_a, st_a, fv_a, fl_a); end
        checks++; if (pc_b !== 64'h20 || fl_b !== 1'b0 || st_b !== 2'd2) begin errors++; $display("FAIL halt_enter_b got pc=%h fl=%b st=%0d want 20 0 2", pc_b, fl_b, st_b); end
        Halt = 0; Jump = 1; JumpTarget = 64'h200; Stall = 1; Branch = 1; Zero = 1;
        tick();
        checks++; if (pc_a !== 64'h20 || st_a !== 2'd2) begin errors++; $display("FAIL halt_ignore got pc=%h st=%0d want 20 2", pc_a, st_a); end
        clear_in();
        Halt = 1; Resume = 1;
        tick();
        checks++; if (st_a !== 2'd2 || pc_a !== 64'h20) begin errors++; $display("FAIL halt_resume_both got st=%0d pc=%h want 2 20", st_a, pc_a); end
        Halt = 0;
        tick();
        checks++; if (st_a !== 2'd0 || pc_a !== 64'h20 || fv_a !== 1'b1) begin errors++; $display("FAIL resume got st=%0d pc=%h fv=%b want 0 20 1", st_a, pc_a, fv_a); end
        Resume = 0;
        tick();
        checks++; if (pc_a !== 64'h24) begin errors++; $display("FAIL resume_step got %h want 24", pc_a); end
        Halt = 1; Jump = 1; JumpTarget = 64'h300;
        tick();
        checks++; if (pc_a !== 64'h24 || st_a !== 2'd2 || fl_a !== 1'b0) begin errors++; $display("FAIL halt_vs_taken got pc=%h st=%0d fl=%b want 24 2 0", pc_a, st_a, fl_a); end
        clear_in();
        Resume = 1;
        tick();
        clear_in();
    endtask

    task automatic test_flush3();
        for (int i = 0; i < 4; i++) tick();
        BranchPC = 64'h1000; BranchOffset = 64'd4; Branch = 1; Zero = 1;
        tick();
        checks++; if (pc_b !== 64'h1010 || fl_b !== 1'b1) begin errors++; $display("FAIL flush3_first got pc=%h fl=%b want 1010 1", pc_b, fl_b); end
        clear_in();
        tick();
        BranchPC = 64'h2000; BranchOffset = '1; BranchOffset[0] = 1'b0; Branch = 1; Zero = 1;
        tick();
        checks++; if (pc_b !== 64'h1ff8 || fl_b !== 1'b1) begin errors++; $display("FAIL flush3_second got pc=%h fl=%b want 1ff8 1", pc_b, fl_b); end
        clear_in();
        tick();
        checks++; if (pc_b !== 64'h1ffc || fl_b !== 1'b1) begin errors++; $display("FAIL flush3_hold1 got pc=%h fl=%b want 1ffc 1", pc_b, fl_b); end
        tick();
        checks++; if (pc_b !== 64'h2000 || fl_b !== 1'b1) begin errors++; $display("FAIL flush3_hold2 got pc=%h fl=%b want 2000 1", pc_b, fl_b); end
        tick();
        checks++; if (pc_b !== 64'h2004 || fl_b !== 1'b0 || fv_b !== 1'b1) begin errors++; $display("FAIL flush3_end got pc=%h fl=%b fv=%b want 2004 0 1", pc_b, fl_b, fv_b); end
        Jump = 1; JumpTarget = 64'h5000;
        tick();
        clear_in();
        apply_reset();
        checks++; if (pc_b !== 64'd0 || fl_b !== 1'b0 || fv_b !== 1'b0 || st_b !== 2'd0) begin errors++; $display("FAIL flush3_reset got pc=%h fl=%b fv=%b st=%0d want 0 0 0 0", pc_b, fl_b, fv_b, st_b); end
        release_reset();
        tick();
        checks++; if (pc_b !== 64'd4 || fl_b !== 1'b0 || fv_b !== 1'b1) begin errors++; $display("FAIL flush3_post_reset got pc=%h fl=%b fv=%b want 4 0 1", pc_b, fl_b, fv_b); end
    endtask

    task automatic test_wrap();
        Jump = 1; JumpTarget = '1;
        tick();
        clear_in();
        checks++; if (pc_a !== 64'hFFFF_FFFF_FFFF_FFFC || pcp_a !== 64'd0) begin errors++; $display("FAIL wrap_top got pc=%h plus=%h want fffffffffffffffc 0", pc_a, pcp_a); end
        tick();
        checks++; if (pc_a !== 64'd0) begin errors++; $display("FAIL wrap_zero got %h want 0", pc_a); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            Stall        = ($urandom_range(3) == 0);
            Branch       = ($urandom_range(5) == 0);
            Zero         = $urandom_range(1) == 1;
            Jump         = ($urandom_range(9) == 0);
            Halt         = ($urandom_range(24) == 0);
            Resume       = ($urandom_range(3) == 0);
            BranchPC     = {$urandom, $urandom};
            BranchOffset = {$urandom, $urandom};
            JumpTarget   = {$urandom, $urandom};
            tick();
            checks++; if (pc_a !== ma.pc || pcp_a !== ma.pc + 64'd4) begin errors++; $display("FAIL rand_pc_a[%0d] got %h/%h want %h", n, pc_a, pcp_a, ma.pc); end
            checks++; if (fl_a !== ma.fl || fv_a !== ma.fv || st_a !== 2'(ma.mode)) begin errors++; $display("FAIL rand_ctl_a[%0d] got fl=%b fv=%b st=%0d want %b %b %0d", n, fl_a, fv_a, st_a, ma.fl, ma.fv, ma.mode); end
            checks++; if (pc_b !== mb.pc || pcp_b !== mb.pc + 64'd4) begin errors++; $display("FAIL rand_pc_b[%0d] got %h/%h want %h", n, pc_b, pcp_b, mb.pc); end
            checks++; if (fl_b !== mb.fl || fv_b !== mb.fv || st_b !== 2'(mb.mode)) begin errors++; $display("FAIL rand_ctl_b[%0d] got fl=%b fv=%b st=%0d want %b %b %0d", n, fl_b, fv_b, st_b, mb.fl, mb.fv, mb.mode); end
        end
        clear_in();
    endtask

    initial begin
        ma = mreset();
        mb = mreset();
        test_reset();
        test_free_run();
        test_branch();
        test_jump_wins();
        test_stall();
        test_halt();
        test_flush3();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
